i2c_fram_target: RTL and testbench



---
 rtl/i2c_target_pkg.sv | 27 ++
 rtl/i2c_fram_target_if.sv | 21 ++
 rtl/i2c_bus_monitor.sv | 53 +++++
 rtl/i2c_fram_target.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_fram_target.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the FM24CLxx-style I2C FRAM target.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        ACK_ADDR,
        WORD_ADDR,
        ACK_WORD,
        WRITE_DATA,
        ACK_DATA,
        READ_DATA,
        READ_ACK
    } state_t;

    localparam logic [3:0] FRAM_TYPE_ID = 4'b1010;

    localparam int unsigned BIT_CNT_W = 4;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT      = BIT_CNT_W'(7);
    localparam logic [BIT_CNT_W-1:0] BITS_PER_BYTE = BIT_CNT_W'(8);

    // True when the upper seven bits of the address byte select this device.
    function automatic logic addr_match(input logic [6:0] addr, input logic [2:0] dev_sel);
        return addr == {FRAM_TYPE_ID, dev_sel};
    endfunction

endpackage

// File: rtl/i2c_fram_target_if.sv
// Open-drain I2C pad bundle between a bus master model and the FRAM target.
interface i2c_fram_target_if;
    logic scl_i;
    logic sda_i;
    logic sda_o;
    logic sda_t;

    modport master (
        output scl_i,
        output sda_i,
        input  sda_o,
        input  sda_t
    );

    modport slave (
        input  scl_i,
        input  sda_i,
        output sda_o,
        output sda_t
    );
endinterface

// File: rtl/i2c_bus_monitor.sv
// Synchronizes raw SCL/SDA and derives SCL edge strobes plus START/STOP conditions.
module i2c_bus_monitor (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise_c,
    output logic scl_fall_c,
    output logic start_c,
    output logic stop_c
);

    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;
    logic scl_meta_d, scl_sync_d, scl_prev_d;
    logic sda_meta_d, sda_sync_d, sda_prev_d;

    always_comb begin
        scl_meta_d = scl_i;
        scl_sync_d = scl_meta_q;
        scl_prev_d = scl_sync_q;
        sda_meta_d = sda_i;
        sda_sync_d = sda_meta_q;
        sda_prev_d = sda_sync_q;
    end

    // Reset to the idle-high bus level so leaving reset never looks like a START.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_meta_d;
            scl_sync_q <= scl_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_meta_q <= sda_meta_d;
            sda_sync_q <= sda_sync_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign sda_s      = sda_sync_q;
    assign scl_rise_c =  scl_sync_q & ~scl_prev_q;
    assign scl_fall_c = ~scl_sync_q &  scl_prev_q;
    assign start_c    =  scl_sync_q &  scl_prev_q &  sda_prev_q & ~sda_sync_q;
    assign stop_c     =  scl_sync_q &  scl_prev_q & ~sda_prev_q &  sda_sync_q;

endmodule

// File: rtl/i2c_fram_target.sv
// I2C target emulating an FM24CLxx FRAM: byte/page write, current, random and sequential read.
// Define I2C_FRAM_TARGET_WP_EN to add the wp (write-protect) input.
module i2c_fram_target
    import i2c_target_pkg::*;
#(
    parameter logic [2:0]  DEV_SEL  = 3'b000,
    parameter int unsigned DEPTH    = 256,
    parameter logic [7:0]  INIT_VAL = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    i2c_fram_target_if.slave bus,
`ifdef I2C_FRAM_TARGET_WP_EN
    input  logic             wp,
`endif
    output logic             busy,
    output logic             wr_strobe,
    output logic [7:0]       wr_addr,
    output logic [7:0]       wr_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic sda_s, scl_rise_c, scl_fall_c, start_c, stop_c;

    i2c_bus_monitor u_mon (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (bus.scl_i),
        .sda_i      (bus.sda_i),
        .sda_s      (sda_s),
        .scl_rise_c (scl_rise_c),
        .scl_fall_c (scl_fall_c),
        .start_c    (start_c),
        .stop_c     (stop_c)
    );

    state_t               state_q, state_d;
    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]           rx_q, rx_d;
    logic [6:0]           tx_q, tx_d;
    logic [AW-1:0]        ptr_q, ptr_d;
    logic                 sda_t_q, sda_t_d;
    logic                 busy_q, busy_d;
    logic                 wr_strobe_q, wr_strobe_d;
    logic [7:0]           wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic [7:0]           mem_q [DEPTH];

    logic [7:0] rx_byte;
    logic [7:0] mem_rd;
    logic       wr_en;

    assign rx_byte = {rx_q, sda_s};
    assign mem_rd  = mem_q[ptr_q];

`ifdef I2C_FRAM_TARGET_WP_EN
    assign wr_en = ~wp;
`else
    assign wr_en = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        sda_t_d     = sda_t_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        // Bus conditions pre-empt any bit in flight, so a partial byte is simply dropped.
        if (start_c) begin
            state_d = DEV_ADDR;
            cnt_d   = '0;
            sda_t_d = 1'b1;
        end else if (stop_c) begin
            state_d = IDLE;
            sda_t_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: sda_t_d = 1'b1;

                DEV_ADDR, WORD_ADDR, WRITE_DATA: begin
                    if (scl_rise_c && cnt_q != BITS_PER_BYTE) begin
                        rx_d  = rx_byte[6:0];
                        cnt_d = cnt_q + BIT_CNT_W'(1);
                        if (cnt_q == LAST_BIT) begin
                            if (state_q == DEV_ADDR) begin
                                if (addr_match(rx_byte[7:1], DEV_SEL)) busy_d  = 1'b1;
                                else                                   state_d = IDLE;
                            end else if (state_q == WORD_ADDR) begin
                                ptr_d = AW'(rx_byte);
                            end else begin
                                ptr_d = ptr_q + AW'(1);
                                if (wr_en) begin
                                    wr_strobe_d = 1'b1;
                                    wr_addr_d   = 8'(ptr_q);
                                    wr_data_d   = rx_byte;
                                end
                            end
                        end
                    end else if (scl_fall_c && cnt_q == BITS_PER_BYTE) begin
                        sda_t_d = 1'b0;
                        cnt_d   = '0;
                        state_d = (state_q == DEV_ADDR)  ? ACK_ADDR :
                                  (state_q == WORD_ADDR) ? ACK_WORD : ACK_DATA;
                    end
                end

                // rx_q[0] holds the R/W bit of the address byte just acknowledged.
                ACK_ADDR: begin
                    if (scl_fall_c) begin
                        cnt_d = '0;
                        if (rx_q[0]) begin
                            tx_d    = mem_rd[6:0];
                            sda_t_d = mem_rd[7];
                            state_d = READ_DATA;
                        end else begin
                            sda_t_d = 1'b1;
                            state_d = WORD_ADDR;
                        end
                    end
                end

                ACK_WORD, ACK_DATA: begin
                    if (scl_fall_c) begin
                        sda_t_d = 1'b1;
                        cnt_d   = '0;
                        state_d = WRITE_DATA;
                    end
                end

                READ_DATA: begin
                    if (scl_rise_c) begin
                        if (cnt_q == LAST_BIT) ptr_d = ptr_q + AW'(1);
                        cnt_d = cnt_q + BIT_CNT_W'(1);
                    end else if (scl_fall_c) begin
                        if (cnt_q == BITS_PER_BYTE) begin
                            sda_t_d = 1'b1;
                            cnt_d   = '0;
                            state_d = READ_ACK;
                        end else begin
                            sda_t_d = tx_q[6];
                            tx_d    = {tx_q[5:0], 1'b0};
                        end
                    end
                end

                // cnt_q doubles as the "master acknowledged" flag between rise and fall.
                READ_ACK: begin
                    if (scl_rise_c) begin
                        if (sda_s) state_d = IDLE;
                        else       cnt_d   = BIT_CNT_W'(1);
                    end else if (scl_fall_c && cnt_q == BIT_CNT_W'(1)) begin
                        tx_d    = mem_rd[6:0];
                        sda_t_d = mem_rd[7];
                        cnt_d   = '0;
                        state_d = READ_DATA;
                    end
                end

                default: state_d = IDLE;
            endcase
        end

        if (state_d == IDLE) busy_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            ptr_q       <= '0;
            sda_t_q     <= 1'b1;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            sda_t_q     <= sda_t_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)              mem_q        <= '{default: INIT_VAL};
        else if (wr_strobe_d) mem_q[ptr_q] <= wr_data_d;
    end

    assign bus.sda_o = 1'b0;
    assign bus.sda_t = sda_t_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_fram_target.sv
// Directed bench for i2c_fram_target: a bit-banged I2C master on a wired-AND SDA line.
module tb_i2c_fram_target;
    import i2c_target_pkg::*;

    localparam int Q = 8;

    logic       clk;
    logic       rst;
    logic       m_sda;
    logic       busy;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
`ifdef I2C_FRAM_TARGET_WP_EN
    logic       wp;
`endif

    int checks = 0;
    int errors = 0;
    int strobe_cnt;
    logic [7:0] last_wa, last_wd;

    i2c_fram_target_if bus ();

    assign bus.sda_i = m_sda & bus.sda_t;

    i2c_fram_target #(.DEV_SEL(3'b000), .DEPTH(256), .INIT_VAL(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
`ifdef I2C_FRAM_TARGET_WP_EN
        .wp        (wp),
`endif
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) strobe_cnt <= 0;
        else if (wr_strobe) begin
            strobe_cnt <= strobe_cnt + 1;
            last_wa    <= wr_addr;
            last_wd    <= wr_data;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        m_sda = b;
        qwait();
        bus.scl_i = 1'b1;
        qwait();
        r = bus.sda_i;
        qwait();
        bus.scl_i = 1'b0;
        qwait();
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        qwait();
        bus.scl_i = 1'b1;
        qwait();
        m_sda = 1'b0;
        qwait();
        bus.scl_i = 1'b0;
        qwait();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        qwait();
        bus.scl_i = 1'b1;
        qwait();
        m_sda = 1'b1;
        qwait();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack_n);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
        bit_xfer(1'b1, ack_n);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic r;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, r);
            d = {d[6:0], r};
        end
        bit_xfer(nack, r);
    endtask

    initial begin
        logic       a;
        logic       r;
        logic [7:0] d;
        int         s0;

        rst       = 1'b1;
        m_sda     = 1'b1;
        bus.scl_i = 1'b1;
`ifdef I2C_FRAM_TARGET_WP_EN
        wp        = 1'b0;
`endif
        repeat (5) @(negedge clk);
        check("rst_sda_t",     16'(bus.sda_t), 16'h1);
        check("rst_busy",      16'(busy),      16'h0);
        check("rst_wr_strobe", 16'(wr_strobe), 16'h0);
        check("rst_wr_addr",   16'(wr_addr),   16'h0);
        check("rst_wr_data",   16'(wr_data),   16'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte write 5A -> 04
        s0 = strobe_cnt;
        i2c_start();
        send_byte(8'hA0, a); check("wr_ack_dev", 16'(a), 16'h0);
        check("wr_busy", 16'(busy), 16'h1);
        send_byte(8'h04, a); check("wr_ack_word", 16'(a), 16'h0);
        send_byte(8'h5A, a); check("wr_ack_data", 16'(a), 16'h0);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("wr_strobes", 16'(strobe_cnt - s0), 16'd1);
        check("wr_addr",    16'(last_wa),        16'h04);
        check("wr_data",    16'(last_wd),        16'h5A);
        check("wr_busy_stop", 16'(busy),         16'h0);

        // Random read of 04
        i2c_start();
        send_byte(8'hA0, a); check("rr_ack_dev", 16'(a), 16'h0);
        send_byte(8'h04, a); check("rr_ack_word", 16'(a), 16'h0);
        i2c_start();
        send_byte(8'hA1, a); check("rr_ack_rd", 16'(a), 16'h0);
        recv_byte(1'b1, d);  check("rr_data", 16'(d), 16'h5A);
        check("rr_sda_rel", 16'(bus.sda_t), 16'h1);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("rr_busy_stop", 16'(busy), 16'h0);

        // Foreign device address gets no ACK
        i2c_start();
        send_byte(8'hA2, a); check("na_no_ack", 16'(a), 16'h1);
        check("na_busy",  16'(busy),          16'h0);
        check("na_state", 16'(dut.state_q),   16'(IDLE));
        i2c_stop();

        // Page write across the wrap point, then sequential read back
        s0 = strobe_cnt;
        i2c_start();
        send_byte(8'hA0, a); check("pw_ack_dev", 16'(a), 16'h0);
        send_byte(8'hFF, a); check("pw_ack_word", 16'(a), 16'h0);
        send_byte(8'h11, a); check("pw_ack_d0", 16'(a), 16'h0);
        send_byte(8'h22, a); check("pw_ack_d1", 16'(a), 16'h0);
        send_byte(8'h33, a); check("pw_ack_d2", 16'(a), 16'h0);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("pw_strobes",   16'(strobe_cnt - s0), 16'd3);
        check("pw_last_addr", 16'(last_wa),         16'h01);
        check("pw_last_data", 16'(last_wd),         16'h33);
        i2c_start();
        send_byte(8'hA0, a);
        send_byte(8'hFF, a);
        i2c_start();
        send_byte(8'hA1, a); check("sr_ack_rd", 16'(a), 16'h0);
        recv_byte(1'b0, d);  check("sr_d_ff", 16'(d), 16'h11);
        recv_byte(1'b0, d);  check("sr_d_00", 16'(d), 16'h22);
        recv_byte(1'b1, d);  check("sr_d_01", 16'(d), 16'h33);
        i2c_stop();

        // Write C3 to 20, then abort a second write mid-byte
        i2c_start();
        send_byte(8'hA0, a);
        send_byte(8'h20, a);
        send_byte(8'hC3, a); check("ab_ack_c3", 16'(a), 16'h0);
        i2c_stop();
        s0 = strobe_cnt;
        i2c_start();
        send_byte(8'hA0, a);
        send_byte(8'h20, a); check("ab_ack_word", 16'(a), 16'h0);
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, r);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("ab_no_strobe", 16'(strobe_cnt - s0), 16'd0);
        check("ab_busy",      16'(busy),            16'h0);
        i2c_start();
        send_byte(8'hA1, a); check("ab_ack_rd", 16'(a), 16'h0);
        recv_byte(1'b1, d);  check("ab_cur_read", 16'(d), 16'hC3);
        i2c_stop();

`ifdef I2C_FRAM_TARGET_WP_EN
        // Write-protected write is acknowledged but not committed
        wp = 1'b1;
        s0 = strobe_cnt;
        i2c_start();
        send_byte(8'hA0, a);
        send_byte(8'h10, a); check("wp_ack_word", 16'(a), 16'h0);
        send_byte(8'h33, a); check("wp_ack_data", 16'(a), 16'h0);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("wp_no_strobe", 16'(strobe_cnt - s0), 16'd0);
        wp = 1'b0;
        i2c_start();
        send_byte(8'hA0, a);
        send_byte(8'h10, a);
        i2c_start();
        send_byte(8'hA1, a);
        recv_byte(1'b1, d);  check("wp_read", 16'(d), 16'h00);
        i2c_stop();
`endif

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
